oq_mac_tx_adapter: RTL and testbench

//  Per-port stage directly downstream of one output-queue port (out_data_N/out_ctrl_N/out_wr_N/out_rdy_N).

---
 rtl/oq_mac_tx_adapter.sv | 151 +++++++++++++++
 tb/tb_oq_mac_tx_adapter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oq_mac_tx_adapter.sv
// oq_mac_tx_adapter: output-queue port to Avalon-ST MAC TX adapter.
// Buffers the 64-bit data/ctrl word stream in a small FIFO, drops module-header words
// and re-frames the payload with sop/eop/empty behind a one-word output register.
module oq_mac_tx_adapter #(
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned CTRL_WIDTH      = 8,
   parameter int unsigned FIFO_DEPTH_BITS = 3,
   parameter int unsigned EMPTY_WIDTH     = 3
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [DATA_WIDTH-1:0]  in_data_i,
   input  logic [CTRL_WIDTH-1:0]  in_ctrl_i,
   input  logic                   in_wr_i,
   output logic                   in_rdy_o,
   output logic [DATA_WIDTH-1:0]  tx_data_o,
   output logic                   tx_sop_o,
   output logic                   tx_eop_o,
   output logic [EMPTY_WIDTH-1:0] tx_empty_o,
   output logic                   tx_valid_o,
   input  logic                   tx_ready_i,
   output logic                   pkt_sent_o,
   output logic                   fmt_err_o
);

   localparam int unsigned Depth = 2 ** FIFO_DEPTH_BITS;
   localparam int unsigned UsedW = FIFO_DEPTH_BITS + 1;

   typedef enum logic [0:0] {StHdr, StPay} state_e;

   logic [DATA_WIDTH-1:0]      mem_data [Depth];
   logic [CTRL_WIDTH-1:0]      mem_ctrl [Depth];
   logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
   logic [UsedW-1:0]           used_q;

   state_e                     state_q;
   logic [DATA_WIDTH-1:0]      data_q;
   logic                       valid_q, sop_q, eop_q, bad_q;
   logic [EMPTY_WIDTH-1:0]     empty_q;
   logic                       pkt_sent_q, fmt_err_q;

   logic                       fifo_full, head_vld, wr_en, pop, emit, is_hdr, out_free, accept;
   logic [DATA_WIDTH-1:0]      head_data;
   logic [CTRL_WIDTH-1:0]      head_ctrl;
   logic                       ctrl_onehot;
   logic [EMPTY_WIDTH-1:0]     empty_idx;

   assign fifo_full = (used_q == UsedW'(Depth));
   assign head_vld  = (used_q != '0);
   assign wr_en     = in_wr_i && !fifo_full;   // overflow writes are dropped
   assign head_data = mem_data[rd_ptr_q];
   assign head_ctrl = mem_ctrl[rd_ptr_q];
   assign accept    = valid_q && tx_ready_i;
   assign out_free  = !valid_q || tx_ready_i;
   // Headers are discarded regardless of output back-pressure.
   assign is_hdr    = (state_q == StHdr) && (head_ctrl != '0);
   assign pop       = head_vld && (is_hdr || out_free);
   assign emit      = pop && !is_hdr;

   // Two words of slack remain once in_rdy drops.
   assign in_rdy_o  = rst_ni && (used_q <= UsedW'(Depth - 3));

   assign tx_data_o  = data_q;
   assign tx_sop_o   = sop_q;
   assign tx_eop_o   = eop_q;
   assign tx_empty_o = empty_q;
   assign tx_valid_o = valid_q;
   assign pkt_sent_o = pkt_sent_q;
   assign fmt_err_o  = fmt_err_q;

   // Decode the last-word ctrl: one-hot bit k gives k unused bytes.
   always_comb begin
      ctrl_onehot = (head_ctrl != '0) && ((head_ctrl & (head_ctrl - 1'b1)) == '0);
      empty_idx   = '0;
      if (ctrl_onehot) begin
         for (int i = 0; i < int'(CTRL_WIDTH); i++) begin
            if (head_ctrl[i]) empty_idx = EMPTY_WIDTH'(i);
         end
      end
   end

   // FIFO storage, no reset needed.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_data[wr_ptr_q] <= in_data_i;
         mem_ctrl[wr_ptr_q] <= in_ctrl_i;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         used_q   <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
         if (wr_en && !pop)      used_q <= used_q + 1'b1;
         else if (!wr_en && pop) used_q <= used_q - 1'b1;
      end
   end

   // Framing FSM with registered Avalon-ST outputs and completion pulses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StHdr;
         valid_q    <= 1'b0;
         data_q     <= '0;
         sop_q      <= 1'b0;
         eop_q      <= 1'b0;
         empty_q    <= '0;
         bad_q      <= 1'b0;
         pkt_sent_q <= 1'b0;
         fmt_err_q  <= 1'b0;
      end else begin
         pkt_sent_q <= accept && eop_q;
         fmt_err_q  <= accept && eop_q && bad_q;
         if (emit) begin
            valid_q <= 1'b1;
            data_q  <= head_data;
            unique case (state_q)
               StHdr: begin
                  sop_q   <= 1'b1;
                  eop_q   <= 1'b0;
                  empty_q <= '0;
                  bad_q   <= 1'b0;
                  state_q <= StPay;
               end
               StPay: begin
                  sop_q <= 1'b0;
                  if (head_ctrl == '0) begin
                     eop_q   <= 1'b0;
                     empty_q <= '0;
                     bad_q   <= 1'b0;
                  end else begin
                     eop_q   <= 1'b1;
                     empty_q <= empty_idx;
                     bad_q   <= !ctrl_onehot;
                     state_q <= StHdr;
                  end
               end
               default: state_q <= StHdr;
            endcase
         end else if (accept) begin
            valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_oq_mac_tx_adapter.sv
// tb_oq_mac_tx_adapter: scoreboard bench; expected beats are queued as words are written
// and a negedge monitor compares every accepted beat and every completion pulse.
module tb_oq_mac_tx_adapter;

   typedef struct packed {
      logic [63:0] d;
      logic        sop;
      logic        eop;
      logic [2:0]  emp;
      logic        err;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] in_data = '0;
   logic [7:0]  in_ctrl = '0;
   logic        in_wr = 1'b0;
   logic        in_rdy;
   logic [63:0] tx_data;
   logic        tx_sop, tx_eop, tx_valid, pkt_sent, fmt_err;
   logic [2:0]  tx_empty;
   logic        tx_ready = 1'b1;

   int          checks = 0;
   int          failures = 0;
   int          nwr = 0;
   int          ready_mode = 0;
   int          pidx = 0;
   logic        pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   beat_t       expq[$];

   oq_mac_tx_adapter dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .in_data_i  (in_data),
      .in_ctrl_i  (in_ctrl),
      .in_wr_i    (in_wr),
      .in_rdy_o   (in_rdy),
      .tx_data_o  (tx_data),
      .tx_sop_o   (tx_sop),
      .tx_eop_o   (tx_eop),
      .tx_empty_o (tx_empty),
      .tx_valid_o (tx_valid),
      .tx_ready_i (tx_ready),
      .pkt_sent_o (pkt_sent),
      .fmt_err_o  (fmt_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: a payload word's expected beat from the framing rules.
   function automatic beat_t mk(input logic [63:0] d, input logic first, input logic last,
                                input logic [7:0] c);
      beat_t b;
      b.d = d; b.sop = first; b.eop = last; b.emp = 3'd0; b.err = 1'b0;
      if (last) begin
         if ($countones(c) == 1) begin
            for (int k = 0; k < 8; k++) if (c[k]) b.emp = 3'(k);
         end else begin
            b.err = 1'b1;
         end
      end
      return b;
   endfunction

   // tx_ready generator: 0 = always, 1 = fixed pattern, 2 = random, 3 = held low.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: tx_ready = 1'b1;
         1: begin tx_ready = pat[pidx % 6]; pidx++; end
         2: tx_ready = 1'($urandom_range(0, 1));
         default: tx_ready = 1'b0;
      endcase
   end

   // Monitor: compare accepted beats, stall stability and the pulses one cycle later.
   logic        prev_stall = 1'b0;
   logic [63:0] prev_data = '0;
   logic [4:0]  prev_flags = '0;
   logic        pend_sent = 1'b0, pend_err = 1'b0;
   always @(negedge clk) begin
      beat_t e;
      if (!rst_n) begin
         prev_stall = 1'b0; pend_sent = 1'b0; pend_err = 1'b0;
      end else begin
         chk("pkt_sent", 64'(pkt_sent), 64'(pend_sent));
         chk("fmt_err", 64'(fmt_err), 64'(pend_err));
         pend_sent = 1'b0; pend_err = 1'b0;
         if (prev_stall) begin
            chk("stall_data", tx_data, prev_data);
            chk("stall_flags", 64'({tx_valid, tx_sop, tx_eop, tx_empty}),
                64'({1'b1, prev_flags[4:0]}));
         end
         if (tx_valid && tx_ready) begin
            if (expq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_beat: got data %h expected none", tx_data);
            end else begin
               e = expq.pop_front();
               chk("beat_data", tx_data, e.d);
               chk("beat_flags", 64'({tx_sop, tx_eop, tx_empty}), 64'({e.sop, e.eop, e.emp}));
               pend_sent = e.eop; pend_err = e.err;
            end
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         prev_flags = {tx_sop, tx_eop, tx_empty};
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [63:0] d, input logic [7:0] c);
      int w = 0;
      while (!in_rdy && w < 2000) begin step(); w++; end
      if (!in_rdy) begin
         checks++; failures++;
         $display("FAIL in_rdy_timeout: got in_rdy 0 expected 1");
      end else begin
         in_data = d; in_ctrl = c; in_wr = 1'b1;
         step();
         in_wr = 1'b0;
         nwr++;
      end
   endtask

   task automatic send_payload(input int len, input logic [7:0] lastc, input logic [63:0] base,
                               input logic rnd);
      logic [63:0] d;
      logic [7:0]  c;
      for (int i = 0; i < len; i++) begin
         d = rnd ? {$urandom, $urandom} : base + 64'(i);
         c = (i == len - 1) ? lastc : 8'h00;
         expq.push_back(mk(d, i == 0, i == len - 1, c));
         wr(d, c);
      end
   endtask

   task automatic drain();
      int w = 0;
      while (expq.size() != 0 && w < 3000) begin step(); w++; end
      repeat (3) step();
      chk("drain_left", 64'(expq.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      logic [7:0] lc;
      // Reset state
      repeat (3) step();
      chk("rst_valid", 64'(tx_valid), 64'd0);
      chk("rst_flags", 64'({tx_sop, tx_eop, tx_empty, pkt_sent, fmt_err}), 64'd0);
      chk("rst_data", tx_data, 64'd0);
      chk("rst_in_rdy", 64'(in_rdy), 64'd0);
      rst_n = 1'b1;
      step();
      chk("in_rdy_after_rst", 64'(in_rdy), 64'd1);

      // 1: one header + 8 words, last ctrl 0x08
      wr(64'h1111, 8'hFF);
      send_payload(8, 8'h08, 64'hD0D0_0000_0000_0000, 1'b0);
      drain();

      // 2: three headers, then 2 words; check 2-cycle latency
      wr(64'hAAAA, 8'hFF); wr(64'hBBBB, 8'h40); wr(64'hCCCC, 8'hFF);
      repeat (4) step();
      expq.push_back(mk(64'hD0, 1'b1, 1'b0, 8'h00));
      expq.push_back(mk(64'hD1, 1'b0, 1'b1, 8'h80));
      in_data = 64'hD0; in_ctrl = 8'h00; in_wr = 1'b1;
      step();
      chk("lat_t1_valid", 64'(tx_valid), 64'd0);
      in_data = 64'hD1; in_ctrl = 8'h80;
      step();
      in_wr = 1'b0;
      chk("lat_t2_valid", 64'(tx_valid), 64'd1);
      chk("lat_t2_data", tx_data, 64'hD0);
      drain();

      // 3: 20-word packet under a 1,0,0,1,0,1 ready pattern
      pidx = 0; ready_mode = 1;
      wr(64'h2222, 8'h10);
      send_payload(20, 8'h02, 64'h0, 1'b1);
      drain();
      ready_mode = 0;

      // 4: back-pressure fills the buffer; in_rdy must drop with 8 words taken
      ready_mode = 3;
      step(); step();
      n0 = nwr;
      fork
         begin
            wr(64'h3333, 8'hFF);
            send_payload(10, 8'h01, 64'h4000, 1'b0);
         end
         begin
            repeat (30) step();
            chk("bp_in_rdy", 64'(in_rdy), 64'd0);
            chk("bp_words_taken", 64'(nwr - n0), 64'd8);
            ready_mode = 0;
         end
      join
      drain();

      // 5: last-word ctrl decode
      wr(64'h5555, 8'hFF); send_payload(3, 8'h01, 64'h5100, 1'b0);
      wr(64'h5555, 8'hFF); send_payload(3, 8'h80, 64'h5200, 1'b0);
      wr(64'h5555, 8'hFF); send_payload(3, 8'h18, 64'h5300, 1'b0);
      drain();

      // 6: reset mid-packet, leftover ctrl!=0 words, then a clean packet
      ready_mode = 3;
      step();
      wr(64'h6666, 8'hFF);
      wr(64'h6001, 8'h00); wr(64'h6002, 8'h00); wr(64'h6003, 8'h00);
      step();
      chk("pre_rst_valid", 64'(tx_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(tx_valid), 64'd0);
      chk("mid_rst_data", tx_data, 64'd0);
      chk("mid_rst_flags", 64'({tx_sop, tx_eop, tx_empty, pkt_sent, fmt_err, in_rdy}), 64'd0);
      step();
      rst_n = 1'b1;
      ready_mode = 0;
      wr(64'h6004, 8'h01); wr(64'h6005, 8'h20);
      wr(64'h7777, 8'hFF);
      send_payload(8, 8'h08, 64'hD0D0_0000_0000_0100, 1'b0);
      drain();

      // 7: random packets under random back-pressure
      ready_mode = 2;
      for (int p = 0; p < 20; p++) begin
         for (int h = $urandom_range(0, 3); h > 0; h--) wr({$urandom, $urandom},
                                                           8'($urandom_range(1, 255)));
         lc = ($urandom_range(0, 1) == 1) ? 8'(1 << $urandom_range(0, 7))
                                          : 8'($urandom_range(1, 255));
         send_payload($urandom_range(2, 12), lc, 64'h0, 1'b1);
      end
      drain();
      ready_mode = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
